// File: rtl/hit_detector.sv
// Whack-a-mole hit detector: synchronises and debounces the hole buttons,
// then classifies each new press as a score or a miss, allowing one score per mole.
module hit_detector #(
    parameter int NUM_HOLES       = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    localparam int IW = $clog2(NUM_HOLES),
    localparam int CW = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 clkIn,
    input  logic                 reset,
    input  logic                 game_active,
    input  logic [NUM_HOLES-1:0] btn_raw,
    input  logic                 mole_valid,
    input  logic [IW-1:0]        mole_index,
    output logic                 player_scored,
    output logic                 player_missed,
    output logic [IW-1:0]        whack_idx,
    output logic [NUM_HOLES-1:0] btn_state
);

    logic [NUM_HOLES-1:0] sync1_q, sync1_d;
    logic [NUM_HOLES-1:0] sync2_q, sync2_d;
    logic [NUM_HOLES-1:0] btn_state_q, btn_state_d;
    logic [NUM_HOLES-1:0] btn_dly_q, btn_dly_d;
    logic [CW-1:0]        cnt_q [NUM_HOLES];
    logic [CW-1:0]        cnt_d [NUM_HOLES];
    logic                 lockout_q, lockout_d;
    logic                 scored_q, scored_d;
    logic                 missed_q, missed_d;
    logic [IW-1:0]        whack_q, whack_d;

    logic [NUM_HOLES-1:0] press;
    logic [IW-1:0]        press_low;
    logic                 target_hit;

    // Synchroniser and per-bit debounce
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        btn_state_d = btn_state_q;
        btn_dly_d   = btn_state_q;
        cnt_d       = cnt_q;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (sync2_q[i] != btn_state_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_state_d[i] = ~btn_state_q[i];
                    cnt_d[i]       = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    assign press      = btn_state_q & ~btn_dly_q;
    assign target_hit = press[mole_index];

    always_comb begin
        press_low = '0;
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (press[i]) press_low = IW'(i);
        end
    end

    // A hit on the mole's hole wins over any other holes pressed alongside it
    always_comb begin
        scored_d  = 1'b0;
        missed_d  = 1'b0;
        whack_d   = whack_q;
        lockout_d = lockout_q;
        if (game_active && (press != '0)) begin
            whack_d = press_low;
            if (mole_valid && target_hit) begin
                if (!lockout_q) begin
                    scored_d  = 1'b1;
                    lockout_d = 1'b1;
                end
            end else begin
                missed_d = 1'b1;
            end
        end
        if (!mole_valid || !game_active) lockout_d = 1'b0;
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            btn_state_q <= '0;
            btn_dly_q   <= '0;
            for (int i = 0; i < NUM_HOLES; i++) cnt_q[i] <= '0;
            lockout_q   <= 1'b0;
            scored_q    <= 1'b0;
            missed_q    <= 1'b0;
            whack_q     <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            btn_state_q <= btn_state_d;
            btn_dly_q   <= btn_dly_d;
            cnt_q       <= cnt_d;
            lockout_q   <= lockout_d;
            scored_q    <= scored_d;
            missed_q    <= missed_d;
            whack_q     <= whack_d;
        end
    end

    assign player_scored = scored_q;
    assign player_missed = missed_q;
    assign whack_idx     = whack_q;
    assign btn_state     = btn_state_q;

endmodule
